// File: rtl/seg7_digit_capture_if.sv
// seg7_digit_capture_if: segment bus in, decoded digit/error/interval status out.
interface seg7_digit_capture_if #(parameter int CNT_W = 24);
    logic [6:0]       seg_in;
    logic             err_clr;
    logic [3:0]       digit;
    logic             digit_valid;
    logic             pattern_err;
    logic             seq_err;
    logic [CNT_W-1:0] interval;
    logic             interval_valid;
    modport master (output seg_in, err_clr,
                    input  digit, digit_valid, pattern_err, seq_err, interval, interval_valid);
    modport slave  (input  seg_in, err_clr,
                    output digit, digit_valid, pattern_err, seq_err, interval, interval_valid);
endinterface

// File: rtl/seg7_digit_capture.sv
// seg7_digit_capture: filters/decodes a 7-seg bus and checks countdown order.
// Define SEG7_CAPTURE_INTERVAL_EN to measure cycles between legal digits.
module seg7_digit_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 24
) (
    input logic                 clk,
    input logic                 rst_n,
    seg7_digit_capture_if.slave bus
);
    typedef enum logic {IDLE, TRACK} state_t;

    state_t     state_q, state_d;
    logic [6:0] s1_q, s2_q, cand_q, cand_d, com_q, com_d;
    logic [3:0] cnt_q, cnt_d, digit_q, digit_d, dec;
    logic       dv_q, dv_d, perr_q, perr_d, serr_q, serr_d;
    logic       commit, legal, set_perr, set_serr;

    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F:   decode = {1'b1, 4'd0};
            7'h06:   decode = {1'b1, 4'd1};
            7'h5B:   decode = {1'b1, 4'd2};
            7'h4F:   decode = {1'b1, 4'd3};
            7'h66:   decode = {1'b1, 4'd4};
            7'h6D:   decode = {1'b1, 4'd5};
            7'h7D:   decode = {1'b1, 4'd6};
            7'h07:   decode = {1'b1, 4'd7};
            7'h7F:   decode = {1'b1, 4'd8};
            7'h6F:   decode = {1'b1, 4'd9};
            default: decode = {1'b0, 4'd0};
        endcase
    endfunction

    assign {legal, dec} = decode(cand_q);

    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        com_d    = com_q;
        state_d  = state_q;
        digit_d  = digit_q;
        dv_d     = 1'b0;
        commit   = 1'b0;
        set_perr = 1'b0;
        set_serr = 1'b0;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else begin
            cnt_d  = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
            // this edge is the STABLE_CYCLES-th agreeing sample
            commit = (cnt_q == 4'(STABLE_CYCLES - 1)) && (cand_q != com_q);
        end
        if (commit) begin
            com_d = cand_q;
            if (legal) begin
                digit_d  = dec;
                dv_d     = 1'b1;
                state_d  = TRACK;
                set_serr = (state_q == TRACK) && (dec != ((digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1));
            end else begin
                state_d  = IDLE;
                set_perr = (cand_q != 7'h00);
            end
        end
        perr_d = set_perr | (perr_q & ~bus.err_clr);
        serr_d = set_serr | (serr_q & ~bus.err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            com_q   <= '0;
            state_q <= IDLE;
            digit_q <= '0;
            dv_q    <= 1'b0;
            perr_q  <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            s1_q    <= bus.seg_in;
            s2_q    <= s1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            com_q   <= com_d;
            state_q <= state_d;
            digit_q <= digit_d;
            dv_q    <= dv_d;
            perr_q  <= perr_d;
            serr_q  <= serr_d;
        end
    end

    assign bus.digit       = digit_q;
    assign bus.digit_valid = dv_q;
    assign bus.pattern_err = perr_q;
    assign bus.seq_err     = serr_q;

`ifdef SEG7_CAPTURE_INTERVAL_EN
    logic [CNT_W-1:0] icnt_q, icnt_d, ival_q, ival_d, inc;
    logic             iv_q, iv_d, track_commit;

    assign inc          = (&icnt_q) ? icnt_q : icnt_q + CNT_W'(1);
    assign track_commit = commit && legal && (state_q == TRACK);

    always_comb begin
        icnt_d = (commit && legal) ? '0 : inc;
        ival_d = track_commit ? inc : ival_q;
        iv_d   = track_commit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icnt_q <= '0;
            ival_q <= '0;
            iv_q   <= 1'b0;
        end else begin
            icnt_q <= icnt_d;
            ival_q <= ival_d;
            iv_q   <= iv_d;
        end
    end

    assign bus.interval       = ival_q;
    assign bus.interval_valid = iv_q;
`else
    assign bus.interval       = '0;
    assign bus.interval_valid = 1'b0;
`endif
endmodule

// File: tb/tb_seg7_digit_capture.sv
// tb_seg7_digit_capture: directed checks of filtering, decode, order and interval.
module tb_seg7_digit_capture;
`ifdef SEG7_CAPTURE_INTERVAL_EN
    localparam int IV_ON = 1;
`else
    localparam int IV_ON = 0;
`endif
    localparam int SC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0, errors = 0;
    int   dv_cnt, first_dv, iv_seen, iv_val;
    logic [6:0] cd [8] = '{7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};

    seg7_digit_capture_if #(.CNT_W(24)) bus ();
    seg7_digit_capture #(.STABLE_CYCLES(SC), .CNT_W(24)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        bus.seg_in = p;
        dv_cnt = 0; first_dv = 0; iv_seen = 0; iv_val = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (bus.digit_valid === 1'b1) begin
                dv_cnt++;
                if (first_dv == 0) first_dv = i;
                iv_seen = int'(bus.interval_valid);
                iv_val  = int'(bus.interval);
            end
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_digit"}, 32'(bus.digit), 0);
        chk({tag, "_dv"}, 32'(bus.digit_valid), 0);
        chk({tag, "_perr"}, 32'(bus.pattern_err), 0);
        chk({tag, "_serr"}, 32'(bus.seq_err), 0);
        chk({tag, "_ival"}, 32'(bus.interval), 0);
        chk({tag, "_iv"}, 32'(bus.interval_valid), 0);
    endtask

    task automatic pulse_clr();
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
    endtask

    initial begin
        bus.seg_in = 7'h00;
        bus.err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        hold(7'h6F, 100);
        chk("first_latency", 32'(first_dv), 3 + SC);
        chk("first_dv_count", 32'(dv_cnt), 1);
        chk("first_digit", 32'(bus.digit), 9);
        chk("first_iv", 32'(iv_seen), 0);
        chk("first_perr", 32'(bus.pattern_err), 0);
        chk("first_serr", 32'(bus.seq_err), 0);
        hold(7'h7F, 100);
        chk("d8_digit", 32'(bus.digit), 8);
        chk("d8_iv", 32'(iv_seen), IV_ON);
        chk("d8_interval", 32'(iv_val), IV_ON * 100);
        hold(7'h07, 100);
        chk("d7_digit", 32'(bus.digit), 7);
        chk("d7_interval", 32'(iv_val), IV_ON * 100);
        chk("d7_serr", 32'(bus.seq_err), 0);
        hold(7'h7D, 20);
        hold(7'h6D, 20);
        chk("d5_digit", 32'(bus.digit), 5);
        hold(7'h3F, 3);
        chk("glitch_dv_a", 32'(dv_cnt), 0);
        hold(7'h6D, 20);
        chk("glitch_dv_b", 32'(dv_cnt), 0);
        chk("glitch_digit", 32'(bus.digit), 5);
        chk("glitch_serr", 32'(bus.seq_err), 0);
        chk("glitch_perr", 32'(bus.pattern_err), 0);
        hold(7'h7D, 20);
        chk("order_dv", 32'(dv_cnt), 1);
        chk("order_digit", 32'(bus.digit), 6);
        chk("order_serr", 32'(bus.seq_err), 1);
        pulse_clr();
        chk("clr_serr", 32'(bus.seq_err), 0);
        hold(7'h49, 20);
        chk("illegal_dv", 32'(dv_cnt), 0);
        chk("illegal_perr", 32'(bus.pattern_err), 1);
        chk("illegal_digit", 32'(bus.digit), 6);
        hold(7'h6F, 50);
        chk("reidle_digit", 32'(bus.digit), 9);
        chk("reidle_iv", 32'(iv_seen), 0);
        hold(7'h7F, 20);
        chk("int50_digit", 32'(bus.digit), 8);
        chk("int50_interval", 32'(iv_val), IV_ON * 50);
        chk("int50_serr", 32'(bus.seq_err), 0);
        pulse_clr();
        chk("clr_perr", 32'(bus.pattern_err), 0);
        for (int i = 0; i < 8; i++) begin
            hold(cd[i], 12);
            chk("countdown_digit", 32'(bus.digit), 32'(7 - i));
        end
        chk("countdown_serr", 32'(bus.seq_err), 0);
        hold(7'h6F, 12);
        chk("wrap_dv", 32'(dv_cnt), 1);
        chk("wrap_digit", 32'(bus.digit), 9);
        chk("wrap_serr", 32'(bus.seq_err), 0);
        chk("wrap_interval", 32'(iv_val), IV_ON * 12);
        hold(7'h7F, 4);
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        hold(7'h7F, 20);
        chk("post_rst_latency", 32'(first_dv), 3 + SC);
        chk("post_rst_digit", 32'(bus.digit), 8);
        chk("post_rst_iv", 32'(iv_seen), 0);
        chk("post_rst_serr", 32'(bus.seq_err), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
